// File: rtl/dbg_uart_pkg.sv
// Shared types and constants for the debug UART receiver.
// The optional parity stage is enabled by defining DBG_UART_PARITY_EN.
package dbg_uart_pkg;

  // Receiver FSM states. PARITY is only reachable when DBG_UART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uartState_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Tick-phase values at which the FSM samples the line.
  localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic evenParity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dbg_uart_baud_tick.sv
// 16x oversampling tick generator for the debug UART receiver.
// Counts 0..BAUD_DIV-1 and pulses tick for one cycle on the wrap value.
// restart re-phases the counter to 0 so sampling aligns to the start edge.
module dbg_uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk50,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, re-phased on every detected start edge.
  always_ff @(posedge clk50) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/dbg_uart_rx.sv
// Debug UART receiver: 8 data bits, LSB first, 1 stop bit, 16x oversampled.
// Defining DBG_UART_PARITY_EN adds an even-parity bit between data and stop.
//
// Output handshake: rdy rises when a byte lands in dout and stays high until
// the consumer holds rdy_clr high for a cycle (level-sensitive). A byte that
// completes while rdy is still high and rdy_clr is low is dropped and sets the
// sticky overrun flag; rdy_clr also clears overrun.
module dbg_uart_rx
  import dbg_uart_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk50,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic [2:0] stateDbg
);

  logic       rxMeta, rxSync, rxPrev;
  uartState_e state, stateNxt;
  logic [3:0] tickCnt, tickCntNxt;
  logic [2:0] bitCnt, bitCntNxt;
  logic [7:0] shiftReg, shiftNxt;
  logic       acceptPend, acceptNxt;
  logic       restart, tick;
  logic       stopBad;
  logic       parBadNow;

`ifdef DBG_UART_PARITY_EN
  logic parBad, parBadNxt;
  logic parityBad;
  assign parBadNow = parBad;
`else
  assign parBadNow = 1'b0;
`endif

  dbg_uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk50  (clk50),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all preset high so reset never looks like a start edge.
  always_ff @(posedge clk50) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state      <= IDLE;
      tickCnt    <= 4'd0;
      bitCnt     <= 3'd0;
      shiftReg   <= 8'h00;
      acceptPend <= 1'b0;
`ifdef DBG_UART_PARITY_EN
      parBad     <= 1'b0;
`endif
    end else begin
      state      <= stateNxt;
      tickCnt    <= tickCntNxt;
      bitCnt     <= bitCntNxt;
      shiftReg   <= shiftNxt;
      acceptPend <= acceptNxt;
`ifdef DBG_UART_PARITY_EN
      parBad     <= parBadNxt;
`endif
    end
  end

  // Next-state logic: ticks advance the bit phase, samples happen at phase 7
  // for the start bit and phase 15 for every later bit (centre of each bit).
  always_comb begin
    stateNxt   = state;
    tickCntNxt = tickCnt;
    bitCntNxt  = bitCnt;
    shiftNxt   = shiftReg;
    acceptNxt  = 1'b0;
    restart    = 1'b0;
    stopBad    = 1'b0;
`ifdef DBG_UART_PARITY_EN
    parBadNxt  = parBad;
    parityBad  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rxPrev && !rxSync) begin
          restart    = 1'b1;
          tickCntNxt = 4'd0;
          stateNxt   = START;
        end
      end
      START: begin
        if (tick) begin
          if (tickCnt == TICK_MID) begin
            tickCntNxt = 4'd0;
            bitCntNxt  = 3'd0;
            // A line already back high at mid-start was only a glitch.
            stateNxt   = rxSync ? IDLE : DATA;
          end else begin
            tickCntNxt = tickCnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tickCnt == TICK_LAST) begin
            tickCntNxt = 4'd0;
            shiftNxt   = {rxSync, shiftReg[7:1]};
            bitCntNxt  = bitCnt + 3'd1;
            if (bitCnt == BIT_LAST) begin
`ifdef DBG_UART_PARITY_EN
              stateNxt = PARITY;
`else
              stateNxt = STOP;
`endif
            end
          end else begin
            tickCntNxt = tickCnt + 4'd1;
          end
        end
      end
`ifdef DBG_UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tickCnt == TICK_LAST) begin
            tickCntNxt = 4'd0;
            parBadNxt  = (rxSync != evenParity(shiftReg));
            stateNxt   = STOP;
          end else begin
            tickCntNxt = tickCnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tickCnt == TICK_LAST) begin
            tickCntNxt = 4'd0;
            stopBad    = !rxSync;
`ifdef DBG_UART_PARITY_EN
            parityBad  = parBad;
`endif
            acceptNxt  = rxSync && !parBadNow;
            // A low stop bit may be a break; wait for the line to idle.
            stateNxt   = rxSync ? IDLE : WAIT_IDLE;
          end else begin
            tickCntNxt = tickCnt + 4'd1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxSync) begin
          stateNxt = IDLE;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // Output holding register: accept one cycle after the stop sample, with
  // overrun protection, and level-sensitive clearing by the consumer.
  always_ff @(posedge clk50) begin
    if (rst) begin
      dout    <= 8'h00;
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end else if (acceptPend) begin
      if (rdy && !rdy_clr) begin
        overrun <= 1'b1;
      end else begin
        dout <= shiftReg;
        rdy  <= 1'b1;
        if (rdy_clr) begin
          overrun <= 1'b0;
        end
      end
    end else if (rdy_clr) begin
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign frame_err = stopBad & ~rst;
`ifdef DBG_UART_PARITY_EN
  assign parity_err = parityBad & ~rst;
`else
  assign parity_err = 1'b0;
`endif
  assign busy     = (state != IDLE);
  assign stateDbg = state;

endmodule

// File: tb/tb_dbg_uart_rx.sv
// Self-checking bench for dbg_uart_rx. Driver tasks serialise frames and push
// the expected receiver events into exp_q; an independent monitor pops and
// compares whenever the DUT shows a delivered byte or an error pulse.
// Build with DBG_UART_PARITY_EN defined to exercise the parity variant.
`timescale 1ns/1ps
module tb_dbg_uart_rx;

  localparam int BD       = 27;
  localparam int BIT_CLKS = 16 * BD;
`ifdef DBG_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_BOUND = FRAME_BITS * BIT_CLKS + 8;

  localparam logic [1:0] EV_BYTE = 2'd0;
  localparam logic [1:0] EV_FERR = 2'd1;
  localparam logic [1:0] EV_PERR = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk50 = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy, busy, frame_err, parity_err, overrun;
  logic [2:0] stateDbg;

  always #10 clk50 = ~clk50;

  dbg_uart_rx #(.BAUD_DIV(BD)) dut (
    .clk50     (clk50),
    .rst       (rst),
    .rx        (rx),
    .dout      (dout),
    .rdy       (rdy),
    .rdy_clr   (rdy_clr),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .stateDbg  (stateDbg)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         nTests = 0;
  int         nFail = 0;
  logic [7:0] mDout = 8'h00;
  logic       mRdy = 1'b0;
  logic       mOverrun = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of one frame at the level of "what the consumer sees".
  task automatic model_frame(input logic [7:0] b, input logic stopOk,
                             input logic parOk, input logic clrHeld);
    if (clrHeld) begin
      mRdy     = 1'b0;
      mOverrun = 1'b0;
    end
    if (!stopOk) exp_q.push_back({EV_FERR, 8'h00});
    if (!parOk) exp_q.push_back({EV_PERR, 8'h00});
    if (stopOk && parOk) begin
      if (mRdy) begin
        mOverrun = 1'b1;
      end else begin
        mDout = b;
        mRdy  = 1'b1;
        exp_q.push_back({EV_BYTE, b});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Leaves rx at the stop-bit value so callers can extend a break.
  task automatic send_frame(input logic [7:0] b, input logic stopBit, input logic parBit);
    @(negedge clk50);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk50);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk50);
    end
    if (FRAME_BITS == 11) begin
      rx = parBit;
      repeat (BIT_CLKS) @(negedge clk50);
    end
    rx = stopBit;
    repeat (BIT_CLKS) @(negedge clk50);
  endtask

  task automatic settle();
    rx = 1'b1;
    repeat (6) @(negedge clk50);
  endtask

  task automatic good_frame(input logic [7:0] b);
    model_frame(b, 1'b1, 1'b1, 1'b0);
    send_frame(b, 1'b1, ^b);
    settle();
  endtask

  task automatic pulse_clr();
    @(negedge clk50);
    rdy_clr = 1'b1;
    @(negedge clk50);
    rdy_clr  = 1'b0;
    mRdy     = 1'b0;
    mOverrun = 1'b0;
    repeat (2) @(negedge clk50);
  endtask

  task automatic post_check(input string tag);
    chk($sformatf("%s_dout", tag), 32'(dout), 32'(mDout));
    chk($sformatf("%s_rdy", tag), 32'(rdy), 32'(mRdy));
    chk($sformatf("%s_overrun", tag), 32'(overrun), 32'(mOverrun));
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_queue_drained", tag), 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  task automatic pop_check(input string name, input logic [9:0] seen);
    logic [9:0] want;
    if (exp_q.size() == 0) begin
      nTests++;
      nFail++;
      $display("FAIL %s: unexpected event %0h, required none, at %0t", name, seen, $time);
    end else begin
      want = exp_q.pop_front();
      chk(name, 32'(seen), 32'(want));
    end
  endtask

  initial begin
    logic       prevRdy;
    logic [7:0] prevDout;
    prevRdy  = 1'b0;
    prevDout = 8'h00;
    forever begin
      @(posedge clk50);
      #1;
      if (frame_err) pop_check("frame_err_evt", {EV_FERR, 8'h00});
      if (parity_err) pop_check("parity_err_evt", {EV_PERR, 8'h00});
      if (!rst && rdy && (!prevRdy || dout != prevDout)) pop_check("byte_evt", {EV_BYTE, dout});
      if (!rst && !rdy && dout != prevDout) begin
        nTests++;
        nFail++;
        $display("FAIL dout_change_without_rdy: got %0h required %0h", dout, prevDout);
      end
      prevRdy  = rdy;
      prevDout = dout;
    end
  end

  // Hard stop in case something wedges.
  initial begin
    #(20 * 120000);
    nFail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       stopOk, parOk, seen;

    // Reset values.
    repeat (5) @(negedge clk50);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_state", 32'(stateDbg), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk50);

    // Clean frame with latency bound.
    model_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        int cnt;
        cnt = 0;
        wait (rx == 1'b0);
        while (!rdy && cnt < LAT_BOUND) begin
          @(posedge clk50);
          #1;
          cnt++;
        end
        chk("a5_rdy_within_bound", 32'(rdy), 32'd1);
      end
    join
    settle();
    post_check("a5");
    pulse_clr();
    chk("a5_clr_rdy", 32'(rdy), 32'd0);

    // Short low glitch is rejected at mid-start.
    @(negedge clk50);
    rx = 1'b0;
    repeat (100) @(negedge clk50);
    chk("glitch_busy_during", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk50);
    post_check("glitch");

    // Bad stop bit followed by a held break.
    model_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (2 * BIT_CLKS) @(negedge clk50);
    chk("break_busy", 32'(busy), 32'd1);
    chk("break_rdy", 32'(rdy), 32'd0);
    rx = 1'b1;
    repeat (8) @(negedge clk50);
    post_check("break");

    // Overrun: second byte without acknowledge is dropped.
    good_frame(8'h11);
    good_frame(8'h22);
    post_check("overrun");
    pulse_clr();
    chk("overrun_clr_rdy", 32'(rdy), 32'd0);
    chk("overrun_clr_flag", 32'(overrun), 32'd0);

    // Acknowledge held through the second frame: new byte replaces the old.
    good_frame(8'h11);
    @(negedge clk50);
    rdy_clr = 1'b1;
    model_frame(8'h22, 1'b1, 1'b1, 1'b1);
    seen = 1'b0;
    fork
      send_frame(8'h22, 1'b1, ^8'h22);
      begin
        for (int i = 0; i < LAT_BOUND && !seen; i++) begin
          @(posedge clk50);
          #1;
          if (rdy && dout == 8'h22) seen = 1'b1;
        end
        rdy_clr = 1'b0;
      end
    join
    chk("clr_held_accept_seen", 32'(seen), 32'd1);
    settle();
    post_check("clr_held");

`ifdef DBG_UART_PARITY_EN
    // Wrong parity bit: byte dropped, parity_err pulse.
    pulse_clr();
    model_frame(8'h07, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, ~(^8'h07));
    settle();
    post_check("parity_bad");
`endif

    // Randomised frames against the model.
    for (int n = 0; n < 4; n++) begin
      b      = 8'($urandom_range(0, 255));
      stopOk = ($urandom_range(0, 3) != 0);
      parOk  = (FRAME_BITS == 11) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ($urandom_range(0, 1) == 1) pulse_clr();
      model_frame(b, stopOk, parOk, 1'b0);
      send_frame(b, stopOk, parOk ? ^b : ~(^b));
      settle();
      post_check($sformatf("rand%0d", n));
    end

    // Reset in the middle of a frame abandons it silently.
    pulse_clr();
    good_frame(8'h5A);
    @(negedge clk50);
    rx = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk50);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (4) @(negedge clk50);
    mDout    = 8'h00;
    mRdy     = 1'b0;
    mOverrun = 1'b0;
    chk("midrst_dout", 32'(dout), 32'h00);
    chk("midrst_rdy", 32'(rdy), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rx  = 1'b1;
    rst = 1'b0;
    repeat (FRAME_BITS * BIT_CLKS) @(negedge clk50);
    post_check("midrst_after");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
